// File: rtl/snn_syn_pkg.sv
// rtl/snn_syn_pkg.sv - shared types, op codes and lane saturating add for the weight RMW controller
package snn_syn_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RD   = 2'd1,
      S_WAIT = 2'd2,
      S_WR   = 2'd3
   } state_t;

   localparam logic OP_RD  = 1'b0;
   localparam logic OP_UPD = 1'b1;

   function automatic int lanes_of(input int data_width, input int w_width);
      return data_width / w_width;
   endfunction

   // Operands arrive already sign-extended; int covers the W+1 bit sum for any practical lane width.
   function automatic int sat_add(input int a, input int d, input int w);
      int sum;
      int hi;
      int lo;
      sum = a + d;
      hi  = (1 << (w - 1)) - 1;
      lo  = -(1 << (w - 1));
      if (sum > hi)
         return hi;
      else if (sum < lo)
         return lo;
      else
         return sum;
   endfunction

endpackage

// File: rtl/syn_weight_rmw_lane.sv
// rtl/syn_weight_rmw_lane.sv - one signed weight lane: masked saturating add of a delta
module syn_lane_sat_add
   import snn_syn_pkg::*;
#(
   parameter int W_WIDTH = 8
) (
   input  logic [W_WIDTH-1:0] weight,
   input  logic [W_WIDTH-1:0] delta,
   input  logic               en,
   output logic [W_WIDTH-1:0] result
);

   logic [W_WIDTH-1:0] sum_sat;

   assign sum_sat = W_WIDTH'(sat_add(int'($signed(weight)), int'($signed(delta)), W_WIDTH));
   assign result  = en ? sum_sat : weight;

endmodule

// File: rtl/syn_weight_rmw.sv
// rtl/syn_weight_rmw.sv - read-modify-write controller owning the synaptic weight SRAM port
module syn_weight_rmw
   import snn_syn_pkg::*;
#(
   parameter  int ADDR_WIDTH = 8,
   parameter  int DATA_WIDTH = 32,
   parameter  int W_WIDTH    = 8,
   parameter  int CNT_WIDTH  = 16,
   localparam int LANES      = lanes_of(DATA_WIDTH, W_WIDTH)
) (
   input  logic                  CK,
   input  logic                  RST,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_op,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_delta,
   input  logic [LANES-1:0]      req_mask,
   output logic                  rd_valid,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  upd_done,
   output logic [CNT_WIDTH-1:0]  upd_cnt,
   output logic                  SRAM_CS,
   output logic                  SRAM_WE,
   output logic [ADDR_WIDTH-1:0] SRAM_A,
   output logic [DATA_WIDTH-1:0] SRAM_D,
   input  logic [DATA_WIDTH-1:0] SRAM_Q
);

   state_t                state;
   logic                  op_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] delta_q;
   logic [LANES-1:0]      mask_q;
   logic [DATA_WIDTH-1:0] wbuf;
   logic [DATA_WIDTH-1:0] new_word;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      syn_lane_sat_add #(
         .W_WIDTH (W_WIDTH)
      ) u_lane (
         .weight (SRAM_Q[i*W_WIDTH +: W_WIDTH]),
         .delta  (delta_q[i*W_WIDTH +: W_WIDTH]),
         .en     (mask_q[i]),
         .result (new_word[i*W_WIDTH +: W_WIDTH])
      );
   end

   // Reset gates the strobes combinationally so a WR cycle hit by reset never reaches the array.
   assign req_ready = !RST && (state == S_IDLE);
   assign SRAM_CS   = !RST && ((state == S_RD) || (state == S_WR));
   assign SRAM_WE   = !RST && (state == S_WR);
   assign SRAM_A    = RST ? '0 : addr_q;
   assign SRAM_D    = RST ? '0 : wbuf;

   always_ff @(posedge CK) begin
      if (RST) begin
         state    <= S_IDLE;
         op_q     <= OP_RD;
         addr_q   <= '0;
         delta_q  <= '0;
         mask_q   <= '0;
         wbuf     <= '0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
         upd_done <= 1'b0;
         upd_cnt  <= '0;
      end else begin
         rd_valid <= 1'b0;
         upd_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  op_q    <= req_op;
                  addr_q  <= req_addr;
                  delta_q <= req_delta;
                  mask_q  <= req_mask;
                  state   <= S_RD;
               end
            end
            S_RD: begin
               state <= S_WAIT;
            end
            S_WAIT: begin
               if (op_q == OP_UPD) begin
                  wbuf  <= new_word;
                  state <= S_WR;
               end else begin
                  rd_data  <= SRAM_Q;
                  rd_valid <= 1'b1;
                  state    <= S_IDLE;
               end
            end
            S_WR: begin
               upd_done <= 1'b1;
               if (upd_cnt != '1)
                  upd_cnt <= upd_cnt + CNT_WIDTH'(1);
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_syn_weight_rmw.sv
// tb/tb_syn_weight_rmw.sv - randomized self-checking bench for syn_weight_rmw against a lane-arithmetic model
module tb_syn_weight_rmw;

   localparam int CNT_MAX = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_op = 1'b0;
   logic [7:0]  req_addr = '0;
   logic [31:0] req_delta = '0;
   logic [3:0]  req_mask = '0;
   logic        rd_valid;
   logic [31:0] rd_data;
   logic        upd_done;
   logic [1:0]  upd_cnt;
   logic        sram_cs;
   logic        sram_we;
   logic [7:0]  sram_a;
   logic [31:0] sram_d;
   logic [31:0] sram_q = '0;

   logic [31:0] mem     [256];
   logic [31:0] ref_mem [256];
   int          cnt_model = 0;
   int          n_vec = 0;
   int          n_bad = 0;

   syn_weight_rmw #(
      .ADDR_WIDTH (8),
      .DATA_WIDTH (32),
      .W_WIDTH    (8),
      .CNT_WIDTH  (2)
   ) dut (
      .CK        (clk),
      .RST       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_addr  (req_addr),
      .req_delta (req_delta),
      .req_mask  (req_mask),
      .rd_valid  (rd_valid),
      .rd_data   (rd_data),
      .upd_done  (upd_done),
      .upd_cnt   (upd_cnt),
      .SRAM_CS   (sram_cs),
      .SRAM_WE   (sram_we),
      .SRAM_A    (sram_a),
      .SRAM_D    (sram_d),
      .SRAM_Q    (sram_q)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (sram_cs) begin
         if (sram_we)
            mem[sram_a] <= sram_d;
         else
            sram_q <= mem[sram_a];
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] apply_upd(input logic [31:0] w, input logic [31:0] d, input logic [3:0] m);
      logic [31:0] r;
      int a;
      int b;
      int s;
      r = w;
      for (int i = 0; i < 4; i++) begin
         a = $signed(w[i*8 +: 8]);
         b = $signed(d[i*8 +: 8]);
         s = a + b;
         if (s > 127) s = 127;
         if (s < -128) s = -128;
         if (m[i]) r[i*8 +: 8] = 8'(s);
      end
      return r;
   endfunction

   task automatic wait_ready();
      int n;
      n = 0;
      while (!req_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check_eq("req_ready_wait", req_ready, 1'b1);
   endtask

   task automatic run_req(input bit op, input logic [7:0] a, input logic [31:0] d, input logic [3:0] m,
                          output int cnt_seen);
      logic [31:0] exp_word;
      bit got;
      bit we_seen;
      cnt_seen  = -1;
      req_valid = 1'b1;
      req_op    = op;
      req_addr  = a;
      req_delta = d;
      req_mask  = m;
      wait_ready();
      @(posedge clk); #1;
      req_valid = 1'b0;
      if (op) begin
         ref_mem[a] = apply_upd(ref_mem[a], d, m);
         cnt_model  = (cnt_model >= CNT_MAX) ? CNT_MAX : cnt_model + 1;
      end
      exp_word = ref_mem[a];
      got      = 1'b0;
      we_seen  = 1'b0;
      for (int c = 1; c <= 8 && !got; c++) begin
         we_seen |= sram_we;
         if (!op && rd_valid) begin
            check_eq("rd_latency", c, 3);
            check_eq("rd_data", rd_data, exp_word);
            check_eq("rd_no_we", we_seen, 1'b0);
            got = 1'b1;
         end else if (op && upd_done) begin
            check_eq("upd_latency", c, 4);
            check_eq("upd_ready_back", req_ready, 1'b1);
            check_eq("upd_cnt", upd_cnt, cnt_model);
            check_eq("upd_word", mem[a], exp_word);
            cnt_seen = int'(upd_cnt);
            got = 1'b1;
         end
         if (!got) begin
            @(posedge clk); #1;
         end
      end
      if (!got) check_eq("resp_timeout", 0, 1);
   endtask

   initial begin
      int cs;
      int c;
      int exp_cnt [5] = '{1, 2, 3, 3, 3};
      logic [31:0] w0;

      for (int i = 0; i < 256; i++) begin
         mem[i]     = $urandom;
         ref_mem[i] = mem[i];
      end

      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_ready", req_ready, 1'b0);
      check_eq("rst_cs", sram_cs, 1'b0);
      check_eq("rst_we", sram_we, 1'b0);
      check_eq("rst_a", sram_a, 0);
      check_eq("rst_d", sram_d, 0);
      check_eq("rst_rd_valid", rd_valid, 1'b0);
      check_eq("rst_rd_data", rd_data, 0);
      check_eq("rst_upd_done", upd_done, 1'b0);
      check_eq("rst_upd_cnt", upd_cnt, 0);
      rst = 1'b0;
      #1;
      check_eq("ready_after_rst", req_ready, 1'b1);

      // saturating update on all lanes
      mem[3] = 32'h7F80_0510;
      ref_mem[3] = mem[3];
      run_req(1'b1, 8'd3, 32'h01FF_FE05, 4'b1111, cs);
      check_eq("sat_word_const", mem[3], 32'h7F80_0315);
      check_eq("sat_cnt_const", cs, 1);

      // masked update from the same start word
      mem[3] = 32'h7F80_0510;
      ref_mem[3] = mem[3];
      run_req(1'b1, 8'd3, 32'h0101_0101, 4'b0101, cs);
      run_req(1'b0, 8'd3, 32'h0, 4'b0, cs);

      // two updates to the same word with req_valid held high
      mem[7] = 32'h0;
      ref_mem[7] = 32'h0;
      req_valid = 1'b1;
      req_op    = 1'b1;
      req_addr  = 8'd7;
      req_delta = 32'h0000_0001;
      req_mask  = 4'b0001;
      wait_ready();
      @(posedge clk); #1;
      c = 1;
      while (!req_ready && c < 10) begin
         @(posedge clk); #1;
         c++;
      end
      check_eq("stream_second_accept", c, 4);
      check_eq("stream_first_done", upd_done, 1'b1);
      ref_mem[7] = apply_upd(ref_mem[7], 32'h1, 4'b0001);
      cnt_model  = (cnt_model >= CNT_MAX) ? CNT_MAX : cnt_model + 1;
      run_req(1'b1, 8'd7, 32'h0000_0001, 4'b0001, cs);
      check_eq("stream_word_const", mem[7], 32'h0000_0002);

      // reset landing on the write cycle
      w0 = $urandom;
      mem[5] = w0;
      ref_mem[5] = w0;
      req_valid = 1'b1;
      req_op    = 1'b1;
      req_addr  = 8'd5;
      req_delta = 32'h1111_1111;
      req_mask  = 4'b1111;
      wait_ready();
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check_eq("wr_cycle_we", sram_we, 1'b1);
      rst = 1'b1;
      #1;
      check_eq("rst_in_wr_cs", sram_cs, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      cnt_model = 0;
      check_eq("rst_wr_ready", req_ready, 1'b1);
      check_eq("rst_wr_done", upd_done, 1'b0);
      check_eq("rst_wr_cnt", upd_cnt, 0);
      check_eq("rst_wr_word", mem[5], w0);

      // counter saturation sequence
      for (int k = 0; k < 5; k++) begin
         run_req(1'b1, 8'($urandom_range(16, 31)), $urandom, 4'($urandom), cs);
         check_eq("cnt_sat_seq", cs, exp_cnt[k]);
      end

      // random mix over a small address window to force reuse
      for (int k = 0; k < 40; k++) begin
         run_req(1'($urandom), 8'($urandom_range(0, 15)), $urandom, 4'($urandom), cs);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
